// File: rtl/chip8_sprite_draw_seq.sv
// CHIP-8 DXYN sprite draw sequencer: fetches one sprite byte per row from program memory
// and XOR-writes each set pixel into the 64x32 framebuffer, accumulating the VF collision flag.
module chip8_sprite_draw_seq #(
  parameter int WRAP   = 1,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MEM_AW-1:0] sprite_addr,
  input  logic [7:0]        vx,
  input  logic [7:0]        vy,
  input  logic [3:0]        rows,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [5:0]        fb_x,
  output logic [4:0]        fb_y,
  input  logic              fb_rdata,
  output logic              fb_we,
  output logic              fb_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_ADDR,
    S_ROW_DATA,
    S_PIX_ADDR,
    S_PIX_READ,
    S_PIX_WRITE,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [MEM_AW-1:0] base_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [5:0]        x0_q;
  logic [4:0]        y0_q;
  logic [3:0]        rows_q;
  logic [3:0]        r_q;
  logic [2:0]        c_q;
  logic [7:0]        row_bits_q;
  logic              busy_q;
  logic              done_q;
  logic              coll_q;
  logic [5:0]        fb_x_q;
  logic [4:0]        fb_y_q;
  logic              fb_we_q;
  logic              fb_wdata_q;

  logic [3:0]        r_d;
  logic [2:0]        c_d;
  logic [MEM_AW-1:0] row_addr_d;
  logic [6:0]        x_abs;
  logic [5:0]        y_abs;
  logic              in_range;

  assign r_d        = r_q + 4'd1;
  assign c_d        = c_q + 3'd1;
  assign row_addr_d = base_q + MEM_AW'(r_d);

  // Unwrapped pixel position, wide enough to see the overflow past column 63 / row 31.
  assign x_abs    = {1'b0, x0_q} + {4'b0, c_q};
  assign y_abs    = {1'b0, y0_q} + {2'b0, r_q};
  assign in_range = (WRAP != 0) || ((x_abs < 7'd64) && (y_abs < 6'd32));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      mem_addr_q <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      rows_q     <= '0;
      r_q        <= '0;
      c_q        <= '0;
      row_bits_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
      fb_x_q     <= '0;
      fb_y_q     <= '0;
      fb_we_q    <= 1'b0;
      fb_wdata_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q <= sprite_addr;
            x0_q   <= 6'(vx);
            y0_q   <= 5'(vy);
            rows_q <= rows;
            r_q    <= '0;
            c_q    <= '0;
            coll_q <= 1'b0;
            busy_q <= 1'b1;
            if (rows != 4'd0) begin
              mem_addr_q <= sprite_addr;
              state_q    <= S_ROW_ADDR;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end

        S_ROW_ADDR: state_q <= S_ROW_DATA;

        S_ROW_DATA: begin
          row_bits_q <= mem_rdata;
          c_q        <= '0;
          fb_x_q     <= x0_q;
          fb_y_q     <= y0_q + {1'b0, r_q};
          state_q    <= S_PIX_ADDR;
        end

        S_PIX_ADDR: state_q <= S_PIX_READ;

        // fb_rdata is valid here; the write is issued during the following cycle.
        S_PIX_READ: begin
          if (row_bits_q[7] && in_range) begin
            fb_we_q    <= 1'b1;
            fb_wdata_q <= ~fb_rdata;
            if (fb_rdata) begin
              coll_q <= 1'b1;
            end
          end
          state_q <= S_PIX_WRITE;
        end

        S_PIX_WRITE: begin
          fb_we_q    <= 1'b0;
          fb_wdata_q <= 1'b0;
          row_bits_q <= {row_bits_q[6:0], 1'b0};
          if (c_q == 3'd7) begin
            r_q <= r_d;
            if (r_d == rows_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              mem_addr_q <= row_addr_d;
              state_q    <= S_ROW_ADDR;
            end
          end else begin
            c_q     <= c_d;
            fb_x_q  <= x0_q + {3'b0, c_d};
            state_q <= S_PIX_ADDR;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign collision = coll_q;
  assign mem_addr  = mem_addr_q;
  assign fb_x      = fb_x_q;
  assign fb_y      = fb_y_q;
  assign fb_we     = fb_we_q;
  assign fb_wdata  = fb_wdata_q;

endmodule

// File: tb/tb_chip8_sprite_draw_seq.sv
// Bench for chip8_sprite_draw_seq: WRAP=1 and WRAP=0 instances share a memory and framebuffer
// model; a reference framebuffer predicts every pixel write, checked from a scoreboard queue.
`timescale 1ns/1ps
module tb_chip8_sprite_draw_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        wrap_sel = 1'b1;
  logic [11:0] sprite_addr = '0;
  logic [7:0]  vx = '0;
  logic [7:0]  vy = '0;
  logic [3:0]  rows = '0;
  logic [7:0]  mem_rdata = '0;
  logic        fb_rdata = 1'b0;

  logic        start1, start0;
  logic        busy1, done1, coll1, we1, wd1;
  logic        busy0, done0, coll0, we0, wd0;
  logic [11:0] ma1, ma0;
  logic [5:0]  fx1, fx0;
  logic [4:0]  fy1, fy0;

  logic        busy, done, coll, fb_we, fb_wdata;
  logic [11:0] mem_addr;
  logic [5:0]  fb_x;
  logic [4:0]  fb_y;

  assign start1   = start & wrap_sel;
  assign start0   = start & ~wrap_sel;
  assign busy     = wrap_sel ? busy1 : busy0;
  assign done     = wrap_sel ? done1 : done0;
  assign coll     = wrap_sel ? coll1 : coll0;
  assign fb_we    = wrap_sel ? we1 : we0;
  assign fb_wdata = wrap_sel ? wd1 : wd0;
  assign mem_addr = wrap_sel ? ma1 : ma0;
  assign fb_x     = wrap_sel ? fx1 : fx0;
  assign fb_y     = wrap_sel ? fy1 : fy0;

  chip8_sprite_draw_seq #(.WRAP(1), .MEM_AW(12)) u_w1 (
    .clk(clk), .reset(reset), .start(start1), .sprite_addr(sprite_addr),
    .vx(vx), .vy(vy), .rows(rows), .busy(busy1), .done(done1), .collision(coll1),
    .mem_addr(ma1), .mem_rdata(mem_rdata), .fb_x(fx1), .fb_y(fy1),
    .fb_rdata(fb_rdata), .fb_we(we1), .fb_wdata(wd1)
  );

  chip8_sprite_draw_seq #(.WRAP(0), .MEM_AW(12)) u_w0 (
    .clk(clk), .reset(reset), .start(start0), .sprite_addr(sprite_addr),
    .vx(vx), .vy(vy), .rows(rows), .busy(busy0), .done(done0), .collision(coll0),
    .mem_addr(ma0), .mem_rdata(mem_rdata), .fb_x(fx0), .fb_y(fy0),
    .fb_rdata(fb_rdata), .fb_we(we0), .fb_wdata(wd0)
  );

  always #10 clk = ~clk;

  logic [7:0] mem [4096];
  logic       fb [32][64] = '{default: '0};
  logic       ref_fb [32][64] = '{default: '0};

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    fb_rdata  <= fb[fb_y][fb_x];
    if (fb_we) fb[fb_y][fb_x] <= fb_wdata;
  end

  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
    logic       d;
  } wr_t;

  typedef struct {
    logic        wrap;
    logic [11:0] base;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  vx;
    logic [7:0]  vy;
    logic [3:0]  n;
    int          exp_cyc;
    logic        exp_coll;
    int          exp_nw;
    int          poke;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t vt[6];
  int   n_checks = 0;
  int   n_fail = 0;
  int   nwr_seen = 0;
  logic we_prev = 1'b0;

  int          cyc, mnw, ones, dcnt;
  logic        mcoll;
  logic [11:0] a1, prev_ma;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference draw: toggles ref_fb and queues the writes the DUT must issue, in order.
  task automatic model_draw(input logic wrap, input logic [11:0] base, input logic [7:0] x,
                            input logic [7:0] y, input logic [3:0] n,
                            output logic c_out, output int nw);
    logic [7:0] b;
    int px, py;
    c_out = 1'b0;
    nw = 0;
    for (int r = 0; r < int'(n); r++) begin
      b = mem[(int'(base) + r) % 4096];
      for (int c = 0; c < 8; c++) begin
        if (b[7-c]) begin
          px = (int'(x) % 64) + c;
          py = (int'(y) % 32) + r;
          if (wrap || (px < 64 && py < 32)) begin
            px = px % 64;
            py = py % 32;
            if (ref_fb[py][px]) c_out = 1'b1;
            ref_fb[py][px] = ~ref_fb[py][px];
            exp_q.push_back({6'(px), 5'(py), ref_fb[py][px]});
            nw++;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (fb_we) begin
      nwr_seen++;
      chk("we_spacing", int'(we_prev), 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: x=%0d y=%0d wdata=%0d, none expected", fb_x, fb_y, fb_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pixel_write{x,y,wdata}", int'({fb_x, fb_y, fb_wdata}), int'(mon_e));
      end
    end
    we_prev = fb_we;
  end

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;

    //          wrap  base     b0     b1     vx      vy     n     cyc coll nw poke
    vt[0] = '{1'b1, 12'h050, 8'hF0, 8'h90, 8'd10,  8'd5,  4'd2, 53, 1'b0, 6, 0};
    vt[1] = '{1'b1, 12'h050, 8'hF0, 8'h90, 8'd10,  8'd5,  4'd2, 53, 1'b1, 6, 0};
    vt[2] = '{1'b1, 12'hFFF, 8'hC3, 8'hC3, 8'd62,  8'd31, 4'd2, 53, 1'b0, 8, 0};
    vt[3] = '{1'b0, 12'hFFF, 8'hC3, 8'hC3, 8'd62,  8'd31, 4'd2, 53, 1'b1, 2, 0};
    vt[4] = '{1'b1, 12'h200, 8'hFF, 8'hFF, 8'd200, 8'd0,  4'd0, 1,  1'b0, 0, 0};
    vt[5] = '{1'b1, 12'h100, 8'h80, 8'h00, 8'd200, 8'd40, 4'd1, 27, 1'b0, 1, 10};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_collision", int'(coll), 0);
    chk("rst_fb_we", int'(fb_we), 0);
    chk("rst_fb_wdata", int'(fb_wdata), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_fb_x", int'(fb_x), 0);
    chk("rst_fb_y", int'(fb_y), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      a1 = vt[i].base + 12'd1;
      mem[vt[i].base] = vt[i].b0;
      mem[a1] = vt[i].b1;
      wrap_sel    = vt[i].wrap;
      sprite_addr = vt[i].base;
      vx          = vt[i].vx;
      vy          = vt[i].vy;
      rows        = vt[i].n;
      prev_ma     = mem_addr;
      exp_q.delete();
      model_draw(vt[i].wrap, vt[i].base, vt[i].vx, vt[i].vy, vt[i].n, mcoll, mnw);
      nwr_seen = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 600) begin
        @(negedge clk);
        cyc++;
        if (cyc == vt[i].poke) begin
          start = 1'b1;
          rows  = 4'd0;
          vx    = 8'd0;
        end else if (start) begin
          start = 1'b0;
          rows  = vt[i].n;
          vx    = vt[i].vx;
        end
      end
      chk("done_cycle", cyc, vt[i].exp_cyc);
      chk("collision_at_done", int'(coll), int'(vt[i].exp_coll));
      chk("collision_vs_model", int'(coll), int'(mcoll));
      chk("busy_at_done", int'(busy), 1);
      chk("write_count", nwr_seen, vt[i].exp_nw);
      chk("writes_pending", exp_q.size(), 0);
      if (vt[i].n == 4'd0) chk("no_mem_access", int'(mem_addr), int'(prev_ma));
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
      chk("done_single_pulse", int'(done), 0);
      chk("collision_held", int'(coll), int'(vt[i].exp_coll));
      if (i == 1) begin
        ones = 0;
        for (int yy = 0; yy < 32; yy++)
          for (int xx = 0; xx < 64; xx++)
            if (fb[yy][xx]) ones++;
        chk("fb_restored", ones, 0);
      end
      repeat (2) @(negedge clk);
    end

    // Reset while row 0 is in PIX_READ: the draw must vanish without a write or done.
    wrap_sel    = 1'b1;
    sprite_addr = 12'h050;
    vx          = 8'd10;
    vy          = 8'd5;
    rows        = 4'd2;
    exp_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_collision", int'(coll), 0);
    reset = 1'b0;
    nwr_seen = 0;
    dcnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("reset_no_done", dcnt, 0);
    chk("reset_no_write", nwr_seen, 0);
    chk("reset_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chip8_sprite_draw_seq.md
Name: chip8_sprite_draw_seq

Overview:
- Sequences one CHIP-8 DXYN sprite draw against the 4 KB program memory and the 64x32 monochrome framebuffer.
- Per sprite row: fetches one byte from memory at I+row, then read-modify-writes each pixel with XOR, accumulating the VF collision flag.
- Sits between the CPU and the memory/framebuffer ports. The top level muxes its address and write-enable outputs onto those ports while busy is high.

Parameters:
- WRAP, 1, 1: out-of-range pixel coordinates wrap modulo 64/32. 0: out-of-range pixels are clipped (skipped).
- MEM_AW, 12, memory address width.

Ports:
- clk, input, 1, system clock (50 MHz).
- reset, input, 1, synchronous, active-high.
- start, input, 1, one-cycle draw request; sampled only in IDLE.
- sprite_addr, input, MEM_AW, value of I; sprite base address.
- vx, input, 8, X coordinate (register Vx).
- vy, input, 8, Y coordinate (register Vy).
- rows, input, 4, N: sprite height, 0..15.
- busy, output, 1, high from the cycle after start is accepted through the DONE cycle.
- done, output, 1, one-cycle completion pulse.
- collision, output, 1, sticky VF result; valid when done is high; held until the next accepted start.
- mem_addr, output, MEM_AW, memory read address.
- mem_rdata, input, 8, memory read data; synchronous, 1-cycle latency.
- fb_x, output, 6, framebuffer pixel column.
- fb_y, output, 5, framebuffer pixel row.
- fb_rdata, input, 1, framebuffer pixel read data; synchronous, 1-cycle latency.
- fb_we, output, 1, framebuffer pixel write enable.
- fb_wdata, output, 1, framebuffer pixel write data.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: state IDLE; busy=0, done=0, collision=0, fb_we=0, fb_wdata=0, mem_addr=0, fb_x=0, fb_y=0.
- Reset mid-draw: aborts immediately. No further fb_we and no done pulse are issued.
- On accepting start in IDLE, latch all inputs:
  - x0 = vx mod 64 and y0 = vy mod 32 (start position always wraps, for both WRAP values).
  - Clear collision, row counter r=0, column counter c=0.
- State machine:
  - IDLE: on start, go to ROW_ADDR if rows!=0, else go to DONE.
  - ROW_ADDR (1 cycle): mem_addr = (sprite_addr + r) mod 2^MEM_AW; base+r wraps at 12 bits.
  - ROW_DATA (1 cycle): latch mem_rdata into the row shift register; c=0.
  - PIX_ADDR (1 cycle): fb_x = (x0 + c) mod 64, fb_y = (y0 + r) mod 32. Bit under test = row byte bit (7-c), MSB is leftmost.
  - PIX_READ (1 cycle): fb_rdata becomes valid.
  - PIX_WRITE (1 cycle):
    - If the bit is 1 and the pixel is in range: fb_we=1, fb_wdata = ~fb_rdata; if fb_rdata==1, set collision.
    - Otherwise fb_we=0.
    - If c==7: r++, then go to ROW_ADDR, or to DONE if r+1==rows. Else c++, go to PIX_ADDR.
  - DONE (1 cycle): done=1, busy=1; next state IDLE.
- In-range test:
  - WRAP=1: always in range.
  - WRAP=0: x0+c < 64 and y0+r < 32. Clipped pixels still consume their 3 cycles but never assert fb_we.
- Timing is deterministic:
  - Each row takes 2 + 8*3 = 26 cycles.
  - done pulses exactly 1 + 26*rows cycles after the start-accept edge. rows=0 gives done 1 cycle after.
- fb_we is high only in PIX_WRITE and never for two consecutive cycles. mem_addr and fb_x/fb_y hold their value between updates.
- start while busy is ignored; it is not queued. A start coincident with reset is ignored.
- collision is never cleared except by reset or an accepted start.

Test Plan:
- WRAP=1; I=0x050 holds 0xF0,0x90; fb all 0; vx=10, vy=5, rows=2 -> done at cycle 53 after start. fb_we pulses only at (10..13,5), (10,6), (13,6), all with wdata=1; collision=0.
- Repeat the same draw on the resulting fb -> the same 6 pixels are written with wdata=0; collision=1; fb returns to all 0.
- WRAP=1; vx=62, vy=31, byte 0xC3, rows=2 -> writes at x {62,63,4,5} on y=31, then on y=0. I+1 wraps correctly when I=0xFFF, fetching address 0x000.
- WRAP=0; same as the previous case -> writes only x=62,63 on y=31; zero fb_we for row 1; done still at cycle 53.
- rows=0 -> done 1 cycle after start, no mem or fb activity, collision=0. vx=200 is reduced to x0=8 for any nonzero rows.
- Assert reset during PIX_READ of row 0 -> busy=0 next cycle, no fb_we, no done. A start during busy is ignored and the draw finishes at the original cycle.
